// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one 256x16 instruction memory between the CPU fetch
// port and a loader port. Round-robin arbitration in ARB; the loader can lock
// the memory for a burst (LOCK). Read data comes back one cycle after the grant.
// Optional feature: define IMEM_STALL_CNT_EN to count fetch stall cycles on
// stall_cnt; without it stall_cnt is tied to zero.
module imem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [7:0]  fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [15:0] fetch_rdata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic        ld_lock,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_wdata,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [15:0] ld_rdata,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_LD    = 1'b1;

    state_t state;
    state_t state_next;
    logic   last_gnt;

    // Grant decision and next state; a sole requester wins at once, a tie goes
    // to whoever did not win last, and LOCK hands the memory to the loader only.
    always_comb begin
        fetch_gnt  = 1'b0;
        ld_gnt     = 1'b0;
        state_next = state;
        case (state)
            ARB: begin
                if (fetch_req && ld_req) begin
                    if (last_gnt == GNT_LD) begin
                        fetch_gnt = 1'b1;
                    end else begin
                        ld_gnt = 1'b1;
                    end
                end else begin
                    fetch_gnt = fetch_req;
                    ld_gnt    = ld_req;
                end
                if (ld_gnt && ld_lock) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                ld_gnt = ld_req;
                if (!ld_lock) begin
                    state_next = ARB;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // Memory bus follows the winner; everything is driven to zero when idle.
    always_comb begin
        mem_addr  = 8'h00;
        mem_we    = 1'b0;
        mem_wdata = 16'h0000;
        if (fetch_gnt) begin
            mem_addr = fetch_addr;
        end else if (ld_gnt) begin
            mem_addr  = ld_addr;
            mem_we    = ld_we;
            mem_wdata = ld_wdata;
        end
    end

    // State register; reset always drops back to arbitration, even from LOCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Remember the most recent winner so ties alternate.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= GNT_LD;
        end else if (fetch_gnt) begin
            last_gnt <= GNT_FETCH;
        end else if (ld_gnt) begin
            last_gnt <= GNT_LD;
        end
    end

    // Capture read data for the winning reader; rdata holds until its next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_rvalid <= 1'b0;
            fetch_rdata  <= 16'h0000;
            ld_rvalid    <= 1'b0;
            ld_rdata     <= 16'h0000;
        end else begin
            fetch_rvalid <= fetch_gnt;
            ld_rvalid    <= ld_gnt && !ld_we;
            if (fetch_gnt) begin
                fetch_rdata <= mem_rdata;
            end
            if (ld_gnt && !ld_we) begin
                ld_rdata <= mem_rdata;
            end
        end
    end

`ifdef IMEM_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count cycles where the CPU wanted an instruction but lost, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else if (fetch_req && !fetch_gnt && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus a randomized run for imem_arbiter,
// checked against a transaction-level model with a shadow copy of memory.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [15:0] fetch_rdata;
    logic        ld_req;
    logic        ld_we;
    logic        ld_lock;
    logic [7:0]  ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [15:0] ld_rdata;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] stall_cnt;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem    [256];
    logic [15:0] shadow [256];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: lock flag, who won last, pending read results, stall count.
    logic        m_lock;
    logic        m_last_ld;
    logic        m_frv, m_lrv;
    logic [15:0] m_frd, m_lrd;
    logic [15:0] m_stall;

    // Expected and observed values of the most recent step.
    logic        e_fgnt, e_lgnt, e_mwe, e_frv, e_lrv;
    logic [7:0]  e_maddr;
    logic [15:0] e_mwdata, e_frd, e_lrd, e_stall;
    logic        o_fgnt, o_lgnt, o_mwe, o_frv, o_lrv;
    logic [7:0]  o_maddr;
    logic [15:0] o_mwdata, o_frd, o_lrd, o_stall;

    imem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .ld_req       (ld_req),
        .ld_we        (ld_we),
        .ld_lock      (ld_lock),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_gnt       (ld_gnt),
        .ld_rvalid    (ld_rvalid),
        .ld_rdata     (ld_rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: asynchronous read, write on the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    // Drive one cycle, sample outputs just after the falling edge, predict, advance model.
    task automatic step(input logic rs, input logic fr, input logic [7:0] fa,
                        input logic lr, input logic lwe, input logic llk,
                        input logic [7:0] la, input logic [15:0] lwd);
        @(negedge clk);
        rst = rs; fetch_req = fr; fetch_addr = fa;
        ld_req = lr; ld_we = lwe; ld_lock = llk; ld_addr = la; ld_wdata = lwd;
        #1;
        if (m_lock) begin
            e_fgnt = 1'b0;
            e_lgnt = lr;
        end else begin
            e_fgnt = fr && (!lr || m_last_ld);
            e_lgnt = lr && !e_fgnt;
        end
        e_maddr  = e_fgnt ? fa : (e_lgnt ? la : 8'h00);
        e_mwe    = e_lgnt && lwe;
        e_mwdata = e_lgnt ? lwd : 16'h0000;
        e_frv = m_frv; e_frd = m_frd; e_lrv = m_lrv; e_lrd = m_lrd; e_stall = m_stall;
        o_fgnt = fetch_gnt; o_lgnt = ld_gnt; o_maddr = mem_addr; o_mwe = mem_we;
        o_mwdata = mem_wdata; o_frv = fetch_rvalid; o_frd = fetch_rdata;
        o_lrv = ld_rvalid; o_lrd = ld_rdata; o_stall = stall_cnt;
        if (rs) begin
            m_lock = 1'b0; m_last_ld = 1'b1;
            m_frv = 1'b0; m_lrv = 1'b0; m_frd = 16'h0000; m_lrd = 16'h0000;
            m_stall = 16'h0000;
        end else begin
            m_frv = e_fgnt;
            if (e_fgnt) m_frd = shadow[fa];
            m_lrv = e_lgnt && !lwe;
            if (m_lrv) m_lrd = shadow[la];
            if (e_fgnt) m_last_ld = 1'b0;
            else if (e_lgnt) m_last_ld = 1'b1;
            if (!m_lock && e_lgnt && llk) m_lock = 1'b1;
            else if (m_lock && !llk) m_lock = 1'b0;
`ifdef IMEM_STALL_CNT_EN
            if (fr && !e_fgnt && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
        end
        if (e_lgnt && lwe) shadow[la] = lwd;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if ({o_frv, o_lrv} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_rvalid: got %b expected 00", {o_frv, o_lrv});
        end
        vectors++;
        if ({o_frd, o_lrd} !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", {o_frd, o_lrd});
        end
        vectors++;
        if (o_stall !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_stall: got %h expected 0000", o_stall);
        end
    endtask

    task automatic test_fetch_basic();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if ({o_fgnt, o_lgnt, o_maddr} !== {1'b1, 1'b0, 8'h03}) begin
            miscompares++;
            $display("[TB] FAIL fetch_grant: got %b/%b addr %h expected 1/0 addr 03", o_fgnt, o_lgnt, o_maddr);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if ({o_frv, o_frd} !== {1'b1, 16'h0D1C}) begin
            miscompares++;
            $display("[TB] FAIL fetch_read: got %b %h expected 1 0d1c", o_frv, o_frd);
        end
    endtask

    task automatic test_alternate();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 8'($urandom), 16'($urandom));
            vectors++;
            if ({o_fgnt, o_lgnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("[TB] FAIL alternate[%0d]: got f/l %b%b expected %s", i, o_fgnt, o_lgnt,
                         (i % 2 == 0) ? "fetch" : "loader");
            end
        end
    endtask

    task automatic test_lock_burst();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h20, 1'b1, 1'b1, (i < 3), 8'h20, 16'hBEEF);
            vectors++;
            if ({o_fgnt, o_lgnt, o_mwe} !== 3'b011) begin
                miscompares++;
                $display("[TB] FAIL lock_burst[%0d]: got fgnt/lgnt/we %b%b%b expected 011", i, o_fgnt, o_lgnt, o_mwe);
            end
        end
        step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if (o_fgnt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lock_release: got fetch_gnt %b expected 1", o_fgnt);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if (o_frd !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL lock_written: got %h expected beef", o_frd);
        end
    endtask

    task automatic test_write_then_read();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h05, 16'h1234);
        vectors++;
        if ({o_mwe, o_maddr, o_mwdata} !== {1'b1, 8'h05, 16'h1234}) begin
            miscompares++;
            $display("[TB] FAIL wr_bus: got we %b addr %h data %h expected 1 05 1234", o_mwe, o_maddr, o_mwdata);
        end
        step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if (o_lrv !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_no_rvalid: got ld_rvalid %b expected 0", o_lrv);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if ({o_frv, o_frd} !== {1'b1, 16'h1234}) begin
            miscompares++;
            $display("[TB] FAIL wr_then_rd: got %b %h expected 1 1234", o_frv, o_frd);
        end
    endtask

    task automatic test_reset_in_lock();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 16'h0000);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 16'h0000);
        step(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if ({o_fgnt, o_frv, o_lrv} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_in_lock: got fgnt/frv/lrv %b%b%b expected 100", o_fgnt, o_frv, o_lrv);
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp_stall;
`ifdef IMEM_STALL_CNT_EN
        exp_stall = 16'd10;
`else
        exp_stall = 16'd0;
`endif
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h40, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 8'h40, 16'h0000);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        vectors++;
        if (o_stall !== exp_stall) begin
            miscompares++;
            $display("[TB] FAIL stall_count: got %0d expected %0d", o_stall, exp_stall);
        end
    endtask

    task automatic test_random();
        logic       fr;
        logic [7:0] fa;
        fr = 1'b0;
        fa = 8'h00;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            if (!(fr && !e_fgnt)) begin
                fr = ($urandom_range(0, 3) != 0);
                fa = 8'($urandom);
            end
            step(($urandom_range(0, 40) == 0), fr, fa, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 8'($urandom), 16'($urandom));
            vectors++;
            if ({o_fgnt, o_lgnt} !== {e_fgnt, e_lgnt} || (o_fgnt && o_lgnt)) begin
                miscompares++;
                $display("[TB] FAIL rnd_grant[%0d]: got f/l %b%b expected %b%b", i, o_fgnt, o_lgnt, e_fgnt, e_lgnt);
            end
            vectors++;
            if ({o_maddr, o_mwe, o_mwdata} !== {e_maddr, e_mwe, e_mwdata}) begin
                miscompares++;
                $display("[TB] FAIL rnd_membus[%0d]: got %h %b %h expected %h %b %h", i,
                         o_maddr, o_mwe, o_mwdata, e_maddr, e_mwe, e_mwdata);
            end
            vectors++;
            if ({o_frv, o_frd} !== {e_frv, e_frd}) begin
                miscompares++;
                $display("[TB] FAIL rnd_fetch_rd[%0d]: got %b %h expected %b %h", i, o_frv, o_frd, e_frv, e_frd);
            end
            vectors++;
            if ({o_lrv, o_lrd} !== {e_lrv, e_lrd}) begin
                miscompares++;
                $display("[TB] FAIL rnd_ld_rd[%0d]: got %b %h expected %b %h", i, o_lrv, o_lrd, e_lrv, e_lrd);
            end
            vectors++;
            if (o_stall !== e_stall) begin
                miscompares++;
                $display("[TB] FAIL rnd_stall[%0d]: got %0d expected %0d", i, o_stall, e_stall);
            end
        end
    endtask

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Preload memory under reset, then run every scenario and summarise.
    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = 8'h00;
        ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = 8'h00; ld_wdata = 16'h0000;
        pl_en = 1'b0; pl_addr = 8'h00; pl_data = 16'h0000;
        m_lock = 1'b0; m_last_ld = 1'b1; m_frv = 1'b0; m_lrv = 1'b0;
        m_frd = 16'h0000; m_lrd = 16'h0000; m_stall = 16'h0000; e_fgnt = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 8'(i);
            pl_data = (i == 3) ? 16'h0D1C : 16'($urandom);
            shadow[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        test_reset();
        test_fetch_basic();
        test_alternate();
        test_lock_burst();
        test_write_then_read();
        test_reset_in_lock();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
